// File: rtl/modexp_pkg.sv
// Shared types and constants for the modular-exponentiation sequencer.
package modexp_pkg;

  localparam int WIDTH = 128;
  localparam int IDX_W = 8;

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SCAN,
    SQ_GO,
    SQ_WAIT,
    MUL_GO,
    MUL_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/msb_index.sv
// Combinational leading-one detector: k is the index of the top set bit of value (0 if none).
// Only compiled when MODEXP_SKIP_LZ_EN is defined, since only that build uses it.
`ifdef MODEXP_SKIP_LZ_EN
module msb_index
  import modexp_pkg::*;
(
  input  logic [WIDTH-1:0] value,
  output logic [IDX_W-1:0] k
);

  // Later (higher) set bits overwrite earlier ones, leaving the most significant.
  always_comb begin
    k = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (value[b]) k = IDX_W'(b);
    end
  end

endmodule
`endif

// File: rtl/modexp_ctrl.sv
// Square-and-multiply sequencer: result = msg^exp mod modulus using an external modular multiplier.
// Define MODEXP_SKIP_LZ_EN to skip the exponent's leading zeros (default: all 128 squares run).
module modexp_ctrl #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] msg,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic [WIDTH-1:0] mul_n,
  input  logic             mul_ready,
  input  logic [WIDTH-1:0] mul_result
);
  import modexp_pkg::*;

  state_t           state, state_next;
  word_t            m, e, n, r, r_next, fin_result;
  logic [IDX_W-1:0] i, i_next;
  logic [1:0]       settle;
  logic             finish, fin_err, qual;

  // The multiplier still shows the previous job's ready until its restart has taken effect.
  assign qual = mul_ready && (settle == 2'd0);

`ifdef MODEXP_SKIP_LZ_EN
  logic [IDX_W-1:0] k;

  msb_index u_msb_index (
    .value(e),
    .k    (k)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    r_next     = r;
    i_next     = i;
    finish     = 1'b0;
    fin_err    = 1'b0;
    fin_result = '0;
    case (state)
      IDLE: if (start) state_next = CHECK;
      CHECK: begin
        if (n == '0 || m >= n) begin
          finish     = 1'b1;
          fin_err    = 1'b1;
          state_next = DONE;
        end else if (e == '0) begin
          finish     = 1'b1;
          fin_result = (n == word_t'(1)) ? '0 : word_t'(1);
          state_next = DONE;
        end else begin
          state_next = SCAN;
        end
      end
      SCAN: begin
`ifdef MODEXP_SKIP_LZ_EN
        if (k == '0) begin
          finish     = 1'b1;
          fin_result = m;
          state_next = DONE;
        end else begin
          r_next     = m;
          i_next     = k - IDX_W'(1);
          state_next = SQ_GO;
        end
`else
        // Start from 1 mod n so the residue is already below n when n == 1.
        r_next     = (n == word_t'(1)) ? '0 : word_t'(1);
        i_next     = IDX_W'(WIDTH - 1);
        state_next = SQ_GO;
`endif
      end
      SQ_GO: state_next = SQ_WAIT;
      SQ_WAIT: begin
        if (qual) begin
          r_next = mul_result;
          if (e[i[6:0]]) begin
            state_next = MUL_GO;
          end else if (i == '0) begin
            finish     = 1'b1;
            fin_result = mul_result;
            state_next = DONE;
          end else begin
            i_next     = i - IDX_W'(1);
            state_next = SQ_GO;
          end
        end
      end
      MUL_GO: state_next = MUL_WAIT;
      MUL_WAIT: begin
        if (qual) begin
          r_next = mul_result;
          if (i == '0) begin
            finish     = 1'b1;
            fin_result = mul_result;
            state_next = DONE;
          end else begin
            i_next     = i - IDX_W'(1);
            state_next = SQ_GO;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latching, residue tracking and the registered multiplier/host outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m         <= '0;
      e         <= '0;
      n         <= '0;
      r         <= '0;
      i         <= '0;
      settle    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      result    <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_n     <= '0;
    end else begin
      r         <= r_next;
      i         <= i_next;
      busy      <= (state_next != IDLE) && (state_next != DONE);
      done      <= finish;
      mul_start <= (state == SQ_GO) || (state == MUL_GO);
      if (state == IDLE && start) begin
        m      <= msg;
        e      <= exp;
        n      <= modulus;
        mul_n  <= modulus;
        err    <= 1'b0;
        result <= '0;
      end
      if (finish) begin
        err    <= fin_err;
        result <= fin_result;
      end
      if (state == SQ_GO || state == MUL_GO) begin
        mul_a  <= r;
        mul_b  <= (state == SQ_GO) ? r : m;
        settle <= 2'd2;
      end else if (settle != 2'd0) begin
        settle <= settle - 2'd1;
      end
    end
  end

endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

Square-and-multiply sequencer computing result = msg^exp mod modulus on 128-bit operands. It sits directly downstream of the bit-serial interleaved modular multiplier and is that multiplier's only client. It issues every square and multiply as a multiplier job over a start/ready handshake and accumulates the running residue. The RSA top-level sees one start/done transaction per exponentiation.

## Interface
Parameters:
- WIDTH, 128, operand width; fixed by the multiplier; no other value supported.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock, shared with the multiplier.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- msg  in  128  base; sampled on accepted start.
- exp  in  128  exponent; sampled on accepted start.
- modulus  in  128  modulus; sampled on accepted start.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse when result/err are valid.
- err  out  1  operand error, valid with done and held until next accept.
- result  out  128  residue, valid with done and held until next accept.
- mul_start  out  1  one-cycle pulse; drives the multiplier's active-high synchronous restart.
- mul_a  out  128  multiplier operand a, scanned MSB first.
- mul_b  out  128  multiplier operand b.
- mul_n  out  128  multiplier modulus.
- mul_ready  in  1  multiplier completion flag.
- mul_result  in  128  multiplier product residue.

## Operation
- States: IDLE, CHECK, SCAN, SQ_GO, SQ_WAIT, MUL_GO, MUL_WAIT, DONE.
- IDLE, start=1: latch m=msg, e=exp, n=modulus; go to CHECK. start in any other state is ignored.
- CHECK, error case: n==0 or m>=n gives err=1, result=0, go to DONE.
- CHECK, trivial cases: if e==0, result = (n==1) ? 0 : 1, go to DONE. Otherwise go to SCAN.
- SCAN: sets r and bit index i per Configuration, then goes to SQ_GO. If no bits remain, goes to DONE with result=r.
- SQ_GO: mul_a=mul_b=r, mul_start=1, go to SQ_WAIT.
- SQ_WAIT: on qualified mul_ready, r<=mul_result. If e[i]=1 go to MUL_GO; else decrement i and go to SQ_GO, or to DONE when i was 0.
- MUL_GO: mul_a=r, mul_b=m, mul_start=1, go to MUL_WAIT.
- MUL_WAIT: on qualified mul_ready, r<=mul_result; then decrement i as above.
- Arithmetic: all operands are unsigned 128-bit. r<n always holds, which the multiplier requires. mul_n=n is constant for the whole operation.
- i is an 8-bit down-counter with no wrap. Exit is decided on i==0 before decrementing.

## Timing
- Reset values: busy=0, done=0, err=0, result=0, mul_start=0, mul_a=0, mul_b=0, mul_n=0. State is IDLE.
- mul_a, mul_b and mul_n are registered. They are stable from the mul_start cycle until the matching mul_ready is consumed.
- mul_ready is qualified only from the second cycle after mul_start. This masks the multiplier's stale ready during its restart.
- Multiplier latency is about 260 cycles per job; the sequencer adds 2 cycles per job.
- Total latency is about 262 × (squares + multiplies) + 4 cycles.
- CHECK errors and e==0 give done 3 cycles after accept.
- done is asserted for exactly one cycle, then the block returns to IDLE. A start in the done cycle is ignored.
- reset asserted mid-operation aborts immediately to reset values. A job in flight in the multiplier is abandoned; the next mul_start restarts it.

## Configuration
- MODEXP_SKIP_LZ_EN defined: SCAN locates the top set bit k of e, sets r=m and i=k−1, and skips the first square and multiply. Squares = k; multiplies = popcount(e)−1. If k==0, result=m immediately.
- MODEXP_SKIP_LZ_EN undefined: r=1 and i=127. All 128 squares always run, plus popcount(e) multiplies. This gives constant-structure timing for a given exponent weight.
- result is identical in both builds.

## Structure
- Shared package modexp_pkg holds:
  - WIDTH and word_t (logic[127:0]);
  - the state enum state_t;
  - IDX_W=8.
- One sub-module, msb_index: combinational 128-bit leading-one detector returning k. It is instantiated only under MODEXP_SKIP_LZ_EN.

## Test plan
- Directed scenarios run against a behavioural multiplier model of programmable latency (1 and 260 cycles), and again against the real multiplier.
- msg=4, exp=13, modulus=497 → result=445, err=0, one done pulse.
- msg=5, exp=3, modulus=13 → result=8. With MODEXP_SKIP_LZ_EN: exactly 1 square and 1 multiply issued. Without it: 128 squares and 2 multiplies.
- msg=2, exp=0, modulus=7 → result=1 within 3 cycles; no mul_start. With modulus=1 and msg=0 → result=0.
- msg=9, exp=5, modulus=9 → err=1, result=0, no mul_start. The same holds for modulus=0.
- Reset pulled low during the 3rd SQ_WAIT → all outputs at reset values the same cycle. A new start with msg=4, exp=13, modulus=497 then gives 445.
- start held high for 5 cycles, and start pulsed while busy → exactly one operation and one done pulse.
